uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller for uart_rx. Programs its clock_divider and drains bytes
//  via the data_ready/read_en handshake into a DEPTH-entry show-ahead FIFO. Presents
//  the FIFO to the host with valid/pop, occupancy count and sticky overflow flag.
//  Sits between uart_rx and the host peripheral bus; uart_rx itself is unchanged.
// PARAMETERS
//  WIDTH            8      data bits per frame (matches uart_rx WIDTH)
//  DEPTH            8      FIFO entries; power of two, >= 2
//  ADDR_BITS        3      log2(DEPTH)
//  DEFAULT_DIVIDER  16'h10 clock_divider value after reset
// PORTS
//  clock           in   1           system clock, all logic on rising edge
//  reset           in   1           asynchronous, active-high reset
//  rx_data_ready   in   1           uart_rx.data_ready
//  rx_data         in   WIDTH       uart_rx.data_out
//  rx_read_en      out  1           uart_rx.read_en; one-cycle consume pulse
//  clock_divider   out  16          uart_rx.clock_divider
//  cfg_we          in   1           write strobe for divider
//  cfg_divider     in   16          new divider value
//  pop             in   1           host consumes FIFO head
//  data_out        out  WIDTH       FIFO head (valid when data_valid=1)
//  data_valid      out  1           FIFO non-empty
//  count           out  ADDR_BITS+1 occupancy, 0..DEPTH
//  overflow        out  1           sticky: byte dropped because FIFO full
//  clear_overflow  in   1           clears overflow
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rx_read_en=0, FIFO empty (count=0,
//   data_valid=0, data_out=0), overflow=0, clock_divider=DEFAULT_DIVIDER.
//  FSM, registered outputs:
//   IDLE: rx_data_ready=1 at edge -> capture rx_data at that same edge, go ACK.
//   ACK : rx_read_en=1 for exactly this one cycle -> WAIT.
//   WAIT: rx_read_en=0; stay until rx_data_ready=0 sampled -> IDLE. No re-capture
//         of the same byte while data_ready remains high.
//  Capture rule: write when count<DEPTH, or count==DEPTH with pop=1 in the same
//   cycle (pop retires head, write fills; count stays DEPTH). Otherwise byte dropped,
//   overflow<=1; handshake (ACK/WAIT) still completes so uart_rx is freed.
//  Latency: data_valid/data_out update on the edge after rx_data_ready first sampled
//   high (1 cycle); rx_read_en high on the following cycle.
//  pop with count==0 ignored (no underflow, count stays 0). Simultaneous write+pop
//   with count>0: count unchanged, head advances. Pointers wrap modulo DEPTH.
//  data_out = mem[rd_ptr], combinational from registered pointer (show-ahead).
//  overflow: set has priority over clear_overflow in the same cycle.
//  cfg_we=1: clock_divider<=cfg_divider next edge; cfg_divider==0 ignored (value
//   held). Applied immediately regardless of FSM state; software changes it only
//   when line idle.
//  count arithmetic in ADDR_BITS+1 bits; never exceeds DEPTH.
// TESTING
//  1 Reset: rx_read_en=0, data_valid=0, count=0, overflow=0, clock_divider=16'h0010.
//  2 rx_data=8'h55, rx_data_ready held high until read_en -> rx_read_en high exactly
//    1 cycle; data_valid=1, data_out=8'h55, count=1; pop -> count=0, data_valid=0.
//  3 Push 8'h01..8'h08 then 8'h09 -> count=8, overflow=1; 8 pops yield 01..08;
//    clear_overflow -> overflow=0.
//  4 FIFO full, pop coincident with capture of 8'hA5 -> count stays 8, overflow=0,
//    A5 emerges as 8th pop.
//  5 cfg_we with 16'h0020 -> clock_divider=16'h0020 next cycle; cfg_we with 0 ->
//    remains 16'h0020.
//  6 Assert reset while in ACK -> rx_read_en=0 immediately, count=0, state IDLE;
//    after release, next byte captured normally.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for uart_rx.
// Drains received bytes from uart_rx through the data_ready/read_en handshake into a
// DEPTH-entry show-ahead FIFO. The host reads the FIFO through valid/pop, and can see
// its occupancy and a sticky overflow flag. The block also holds the uart_rx clock
// divider and lets software program it.
//
// Ports:
//   clock, reset           system clock (rising edge); asynchronous active-high reset
//   rx_data_ready, rx_data byte-available flag and byte from uart_rx
//   rx_read_en             one-cycle consume pulse back to uart_rx
//   clock_divider          divider value driven to uart_rx
//   cfg_we, cfg_divider    divider write strobe and value (a zero value is ignored)
//   pop                    host consumes the FIFO head
//   data_out, data_valid   FIFO head and non-empty flag
//   count                  FIFO occupancy, 0..DEPTH
//   overflow               sticky flag: a byte was dropped because the FIFO was full
//   clear_overflow         clears overflow (a new drop in the same cycle wins)
module uart_rx_ctrl #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_BITS       = 3,
  parameter logic [15:0] DEFAULT_DIVIDER = 16'h10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_data_ready,
  input  logic [WIDTH-1:0]     rx_data,
  output logic                 rx_read_en,
  output logic [15:0]          clock_divider,
  input  logic                 cfg_we,
  input  logic [15:0]          cfg_divider,
  input  logic                 pop,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam logic [ADDR_BITS:0]   DepthCnt = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CntOne   = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PtrOne   = ADDR_BITS'(1);

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e                 state_q;
  logic                   rx_read_en_q;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [ADDR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]     count_q, count_d;
  logic                   overflow_q;
  logic [15:0]            divider_q;

  logic capture, do_pop, has_room, do_write, drop;

  always_comb begin
    capture  = (state_q == StIdle) && rx_data_ready;
    do_pop   = pop && (count_q != '0);
    // A pop in the same cycle frees the head slot even when the FIFO is full.
    has_room = (count_q != DepthCnt) || do_pop;
    do_write = capture && has_room;
    drop     = capture && !has_room;
  end

  always_comb begin
    count_d = count_q;
    case ({do_write, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM. The byte is captured on the IDLE edge, so rx_read_en only frees uart_rx.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rx_read_en_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_data_ready) begin
            state_q      <= StAck;
            rx_read_en_q <= 1'b1;
          end
        end
        StAck: begin
          state_q      <= StWait;
          rx_read_en_q <= 1'b0;
        end
        StWait: begin
          // Block re-capture of the same byte until data_ready drops.
          if (!rx_data_ready) state_q <= StIdle;
        end
        default: begin
          state_q      <= StIdle;
          rx_read_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= rx_data;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divider_q <= DEFAULT_DIVIDER;
    end else if (cfg_we && (cfg_divider != 16'h0)) begin
      divider_q <= cfg_divider;
    end
  end

  assign rx_read_en    = rx_read_en_q;
  assign clock_divider = divider_q;
  assign data_out      = mem_q[rd_ptr_q];
  assign data_valid    = (count_q != '0);
  assign count         = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_uart_rx_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic        rx_read_en;
  logic [15:0] clock_divider;
  logic        cfg_we;
  logic [15:0] cfg_divider;
  logic        pop;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [3:0]  count;
  logic        overflow;
  logic        clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  uart_rx_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .rx_data_ready  (rx_data_ready),
    .rx_data        (rx_data),
    .rx_read_en     (rx_read_en),
    .clock_divider  (clock_divider),
    .cfg_we         (cfg_we),
    .cfg_divider    (cfg_divider),
    .pop            (pop),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behaves like uart_rx: holds data_ready until read_en is seen, then drops it.
  // Returns the number of cycles rx_read_en was high; leaves the FSM back in IDLE.
  task automatic push(input logic [7:0] b, input logic with_pop, output int pulses);
    pulses        = 0;
    rx_data       = b;
    rx_data_ready = 1'b1;
    pop           = with_pop;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      pop = 1'b0;
      if (rx_read_en) begin
        pulses++;
        rx_data_ready = 1'b0;
      end
    end
    rx_data_ready = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    @(negedge clock);
    pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset          = 1'b1;
    rx_data_ready  = 1'b0;
    rx_data        = 8'h00;
    cfg_we         = 1'b0;
    cfg_divider    = 16'h0;
    pop            = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: reset state
    check_eq("rst_read_en", rx_read_en, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_divider", clock_divider, 16'h0010);
    check_eq("rst_data_out", data_out, 8'h00);

    // 2: single byte, then pop
    push(8'h55, 1'b0, p);
    check_eq("t2_pulses", p, 1);
    check_eq("t2_valid", data_valid, 1);
    check_eq("t2_data", data_out, 8'h55);
    check_eq("t2_count", count, 1);
    pop_one();
    check_eq("t2_pop_count", count, 0);
    check_eq("t2_pop_valid", data_valid, 0);
    pop_one();
    check_eq("t2_underflow", count, 0);

    // data_ready held high long after the handshake must capture one byte only
    rx_data       = 8'h99;
    rx_data_ready = 1'b1;
    repeat (6) @(negedge clock);
    rx_data_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("hold_count", count, 1);
    check_eq("hold_data", data_out, 8'h99);
    pop_one();
    check_eq("hold_pop_count", count, 0);

    // 3: fill, overflow, drain, clear
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b0, p);
    check_eq("t3_full_count", count, 8);
    check_eq("t3_no_ovf", overflow, 0);
    push(8'h09, 1'b0, p);
    check_eq("t3_ovf_pulses", p, 1);
    check_eq("t3_ovf_count", count, 8);
    check_eq("t3_ovf", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      check_eq("t3_drain", data_out, 32'(i));
      pop_one();
    end
    check_eq("t3_empty_count", count, 0);
    check_eq("t3_empty_valid", data_valid, 0);
    check_eq("t3_ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    check_eq("t3_ovf_clear", overflow, 0);

    // 4: full FIFO, pop coincident with capture
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0, p);
    check_eq("t4_full", count, 8);
    push(8'hA5, 1'b1, p);
    check_eq("t4_count", count, 8);
    check_eq("t4_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      check_eq("t4_drain", data_out, 32'h10 + 32'(i));
      pop_one();
    end
    check_eq("t4_last", data_out, 8'hA5);
    pop_one();
    check_eq("t4_empty", count, 0);

    // 5: divider programming
    cfg_we      = 1'b1;
    cfg_divider = 16'h0020;
    @(negedge clock);
    cfg_we = 1'b0;
    check_eq("t5_div", clock_divider, 16'h0020);
    cfg_we      = 1'b1;
    cfg_divider = 16'h0000;
    @(negedge clock);
    cfg_we = 1'b0;
    check_eq("t5_div_zero", clock_divider, 16'h0020);

    // 6: reset during ACK
    rx_data       = 8'h77;
    rx_data_ready = 1'b1;
    @(negedge clock);
    check_eq("t6_ack_read_en", rx_read_en, 1);
    check_eq("t6_ack_count", count, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_read_en", rx_read_en, 0);
    check_eq("t6_rst_count", count, 0);
    check_eq("t6_rst_valid", data_valid, 0);
    check_eq("t6_rst_div", clock_divider, 16'h0010);
    @(negedge clock);
    rx_data_ready = 1'b0;
    reset         = 1'b0;
    @(negedge clock);
    push(8'h3C, 1'b0, p);
    check_eq("t6_pulses", p, 1);
    check_eq("t6_data", data_out, 8'h3C);
    check_eq("t6_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
